inst_fetch_resp: RTL and testbench

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

---
 rtl/inst_fetch_resp.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_resp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: single-outstanding instruction fetch responder.
// Holds DEPTH 32-bit words that the program-load port fills in.
// An accepted fetch returns its word WAIT_CYCLES+1 cycles after acceptance.
// The response is held until the consumer takes it, or until a flush drops it.
// Optional feature macro: INST_ALIGN_CHK_EN. When it is defined, a misaligned
// PC returns a NOP and raises err.
module inst_fetch_resp #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [31:0]              addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic [31:0]              resp_pc,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  output logic                     err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] NOP      = 32'hE1A00000;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic          accept;
  logic          in_range;
  logic          misaligned;
  logic [AW-1:0] word_idx;
  logic [31:0]   fetch_word;
  logic [31:0]   inst_q;
  logic [31:0]   pc_q;

  // A fetch is taken only in IDLE. A flush in IDLE blocks acceptance for that cycle.
  assign accept   = (state == IDLE) && req && !flush;
  assign word_idx = addr[AW+1:2];
  assign in_range = (addr[31:AW+2] == '0);

`ifdef INST_ALIGN_CHK_EN
  assign misaligned = |addr[1:0];
`else
  // The byte offset is intentionally ignored when alignment checking is off.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];
  assign misaligned      = 1'b0;
`endif

  // Select the word to latch at acceptance: the stored word, or a NOP for a bad PC.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    fetch_word = NOP;
    if (in_range && !misaligned) begin
      fetch_word = mem[word_idx];
    end
  end

  // Program-load write port; active in every state.
  // NOTE: instruction storage has no reset. Its contents survive rst_n, and only
  // the control state below is reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // flush together with resp_ready still discards the response.
        if (flush || resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Wait counter and response capture. Data is frozen at acceptance, so later
  // program writes cannot change an in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments. Every register then
      // updates from pre-edge values, which is why a same-cycle write returns old data.
      cnt    <= 4'd0;
      inst_q <= 32'd0;
      pc_q   <= 32'd0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      inst_q <= fetch_word;
      pc_q   <= addr + 32'd4;
    end else if (state == WAIT) begin
      cnt <= (flush || cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    end
  end

`ifdef INST_ALIGN_CHK_EN
  logic err_q;

  // Misalignment flag, captured with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_inst  = inst_q;
  assign resp_pc    = pc_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp. Directed cases are followed by randomized
// fetches. Expected values come from a word-array model of the program memory.
module tb_inst_fetch_resp;

  localparam int          DEPTH = 64;
  localparam int          W     = 2;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [31:0]   addr;
  logic          req_ready;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_inst;
  logic [31:0]   resp_pc;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  inst_fetch_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .addr       (addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_pc    (resp_pc),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
`ifdef INST_ALIGN_CHK_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] a);
    if ((a >> 2) >= DEPTH) return NOP;
    if (model_err(a)) return NOP;
    return model[int'(a >> 2)];
  endfunction

  task automatic set_write(input int idx, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(idx);
    prog_data = d;
    model[idx] = d;
  endtask

  task automatic prog_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    set_write(idx, d);
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Issue one fetch and follow it until it completes or is flushed.
  // hold:    extra RESP cycles with resp_ready low
  // flush_k: negedge (1 = first cycle after accept) at which flush is raised; 0 = never
  // pw_k:    cycle of an optional program write (0 = same cycle as accept)
  task automatic fetch(input logic [31:0] a, input int hold, input int flush_k,
                       input bit pw_en, input int pw_k, input int pw_idx,
                       input logic [31:0] pw_data);
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_err;
    int          last;
    last = W + 1 + hold;
    @(negedge clk);
    check("idle_req_ready", req_ready, 32'd1);
    e_inst = model_inst(a);
    e_pc   = a + 32'd4;
    e_err  = model_err(a);
    req    = 1'b1;
    addr   = a;
    if (pw_en && pw_k == 0) set_write(pw_idx, pw_data);
    @(negedge clk);
    req     = 1'b0;
    prog_we = 1'b0;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) begin
        @(negedge clk);
        prog_we = 1'b0;
      end
      if (k <= W) begin
        check("wait_resp_valid", resp_valid, 32'd0);
        check("wait_req_ready", req_ready, 32'd0);
      end else begin
        check("resp_valid", resp_valid, 32'd1);
        check("resp_req_ready", req_ready, 32'd0);
        check("resp_inst", resp_inst, e_inst);
        check("resp_pc", resp_pc, e_pc);
        check("resp_err", err, e_err);
      end
      if (pw_en && pw_k == k) set_write(pw_idx, pw_data);
      if (k == last) resp_ready = 1'b1;
      if (k == flush_k) begin
        flush = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        resp_ready = 1'b0;
        prog_we    = 1'b0;
        check("flush_resp_valid", resp_valid, 32'd0);
        check("flush_req_ready", req_ready, 32'd1);
        return;
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
    prog_we    = 1'b0;
    check("done_resp_valid", resp_valid, 32'd0);
    check("done_req_ready", req_ready, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          hold;
    int          fk;
    rst_n = 1'b0; req = 1'b0; addr = '0; flush = 1'b0; resp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Outputs while reset is held.
    @(negedge clk);
    check("rst_req_ready", req_ready, 32'd1);
    check("rst_resp_valid", resp_valid, 32'd0);
    check("rst_resp_inst", resp_inst, 32'd0);
    check("rst_resp_pc", resp_pc, 32'd0);
    check("rst_err", err, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_req_ready", req_ready, 32'd1);

    // Fill the whole program memory.
    for (int i = 0; i < DEPTH; i++) prog_write(i, $urandom());

    // Basic fetch of word 1.
    prog_write(1, 32'hE3A01A01);
    fetch(32'd4, 0, 0, 1'b0, 0, 0, 32'd0);

    // Consumer stalls for 5 cycles.
    fetch(32'd0, 5, 0, 1'b0, 0, 0, 32'd0);

    // Flush on the first wait cycle, then a normal fetch.
    fetch(32'd8, 0, 1, 1'b0, 0, 0, 32'd0);
    fetch(32'd12, 0, 0, 1'b0, 0, 0, 32'd0);

    // Flush at the last wait cycle, flush in RESP, and flush together with resp_ready.
    fetch(32'd16, 0, W, 1'b0, 0, 0, 32'd0);
    fetch(32'd20, 2, W + 2, 1'b0, 0, 0, 32'd0);
    fetch(32'd24, 1, W + 2, 1'b0, 0, 0, 32'd0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    req = 1'b1; flush = 1'b1; addr = 32'd0;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    check("flush_idle_req_ready", req_ready, 32'd1);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      check("flush_idle_no_resp", resp_valid, 32'd0);
    end

    // Out of range, last valid word, and a misaligned PC.
    fetch(DEPTH * 4, 0, 0, 1'b0, 0, 0, 32'd0);
    fetch(DEPTH * 4 - 4, 0, 0, 1'b0, 0, 0, 32'd0);
    fetch(32'd2, 0, 0, 1'b0, 0, 0, 32'd0);

    // Write and accept of the same word in one cycle return the old word; a write
    // during the wait leaves the response unchanged.
    fetch(32'd12, 0, 0, 1'b1, 0, 3, 32'hA5A5_0003);
    fetch(32'd12, 0, 0, 1'b1, 1, 3, 32'h5A5A_1003);
    fetch(32'd12, 0, 0, 1'b0, 0, 0, 32'd0);

    // Reset during WAIT drops the fetch and keeps the memory contents.
    @(negedge clk);
    req = 1'b1; addr = 32'd4;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b0;
    #1 check("rst_wait_resp_valid", resp_valid, 32'd0);
    check("rst_wait_req_ready", req_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      check("rst_wait_no_resp", resp_valid, 32'd0);
    end
    fetch(32'd4, 0, 0, 1'b0, 0, 0, 32'd0);

    // Reset during RESP clears the response registers.
    @(negedge clk);
    req = 1'b1; addr = 32'd8;
    @(negedge clk);
    req = 1'b0;
    repeat (W) @(negedge clk);
    check("pre_rst_resp_valid", resp_valid, 32'd1);
    rst_n = 1'b0;
    #1 check("rst_resp_valid_drop", resp_valid, 32'd0);
    check("rst_resp_inst_clear", resp_inst, 32'd0);
    check("rst_resp_pc_clear", resp_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'd8, 0, 0, 1'b0, 0, 0, 32'd0);

    // Randomized fetches with stalls, flushes and concurrent program writes.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      fk   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1 + hold)) : 0;
      fetch(a, hold, fk, 1'($urandom_range(0, 1)), int'($urandom_range(0, W)),
            int'($urandom_range(0, DEPTH - 1)), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
